// File: rtl/cpu7_ifu_fetch_ctl_pkg.sv
// cpu7_ifu_fetch_ctl_pkg: shared types for the fetch sequencer and its queue.
// Provides FSM state encodings, the {pc,inst} queue entry and the block-advance helper.
package cpu7_ifu_fetch_ctl_pkg;

    localparam int IFQ_ENTRY_W = 64;

    typedef enum logic {
        IFQ_S_REQ  = 1'b0,
        IFQ_S_WAIT = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [IFQ_ENTRY_W/2-1:0] pc;
        logic [IFQ_ENTRY_W/2-1:0] inst;
    } fq_entry_t;

    // Advance to the next aligned 8-byte block; wraps silently at 4 GiB.
    function automatic logic [31:0] next_block(input logic [31:0] fa);
        return {fa[31:3] + 29'd1, 3'b000};
    endfunction

endpackage

// File: rtl/cpu7_ifu_fetch_ctl_if.sv
// cpu7_ifu_fetch_ctl_if: IFU <-> ICU fetch channel (req/addr/ack, cancel, data/valid).
// master = IFU fetch sequencer, slave = ICU.
interface cpu7_ifu_fetch_ctl_if;

    logic        ifu_icu_req_ic1;
    logic [31:0] ifu_icu_addr_ic1;
    logic        icu_ifu_ack_ic1;
    logic        ifu_icu_cancel;
    logic [63:0] icu_ifu_data_ic2;
    logic        icu_ifu_data_valid_ic2;

    modport master (
        output ifu_icu_req_ic1,
        output ifu_icu_addr_ic1,
        output ifu_icu_cancel,
        input  icu_ifu_ack_ic1,
        input  icu_ifu_data_ic2,
        input  icu_ifu_data_valid_ic2
    );

    modport slave (
        input  ifu_icu_req_ic1,
        input  ifu_icu_addr_ic1,
        input  ifu_icu_cancel,
        output icu_ifu_ack_ic1,
        output icu_ifu_data_ic2,
        output icu_ifu_data_valid_ic2
    );

endinterface

// File: rtl/cpu7_ifu_fq.sv
// cpu7_ifu_fq: circular {pc,inst} queue, 1- or 2-entry push, 1-entry pop, flush.
// Ports: i_push/i_push2/i_d0/i_d1 write, i_pop read, i_flush, o_vld/o_head registered head, o_free.
module cpu7_ifu_fq
    import cpu7_ifu_fetch_ctl_pkg::*;
#(
    parameter  int FQ_DEPTH = 4,
    localparam int PW       = $clog2(FQ_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_push2,
    input  fq_entry_t     i_d0,
    input  fq_entry_t     i_d1,
    input  logic          i_pop,
    output logic          o_vld,
    output fq_entry_t     o_head,
    output logic [CW-1:0] o_free
);

    fq_entry_t     r_mem [FQ_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_vld;
    fq_entry_t     r_head;

    logic          w_pop;
    logic [CW-1:0] w_npush;
    logic [CW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_wp1;
    logic [PW-1:0] w_hp;
    fq_entry_t     w_head_nxt;

    assign w_pop     = i_pop && (r_cnt != '0);
    assign w_npush   = !i_push ? '0 : (i_push2 ? CW'(2) : CW'(1));
    assign w_cnt_nxt = r_cnt + w_npush - CW'(w_pop);
    assign w_wp1     = r_wp + PW'(1);
    assign w_hp      = r_rp + PW'(w_pop);
    // If nothing old survives the pop, the new head is the first word pushed now.
    assign w_head_nxt = (r_cnt > CW'(w_pop)) ? r_mem[w_hp] : i_d0;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_d0;
        if (i_push && i_push2) r_mem[w_wp1] <= i_d1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_head <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else begin
            r_wp  <= r_wp + PW'(w_npush);
            r_rp  <= w_hp;
            r_cnt <= w_cnt_nxt;
            r_vld <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) r_head <= w_head_nxt;
        end
    end

    assign o_vld  = r_vld;
    assign o_head = r_head;
    assign o_free = CW'(FQ_DEPTH) - r_cnt;

endmodule

// File: rtl/cpu7_ifu_fetch_ctl.sv
// cpu7_ifu_fetch_ctl: fetch sequencer; one 64-bit ICU request at a time, redirect/cancel, fetch queue.
// Ports: clk/reset, pc_init, except/ertn/branch redirects, icu channel (master), fq_dec_* head, dec_fq_rdy.
module cpu7_ifu_fetch_ctl
    import cpu7_ifu_fetch_ctl_pkg::*;
#(
    parameter int FQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_init,
    input  logic                 exu_ifu_except,
    input  logic [31:0]          exu_ifu_eentry,
    input  logic                 exu_ifu_ertn_e,
    input  logic [31:0]          exu_ifu_era,
    input  logic                 br_taken,
    input  logic [31:0]          br_target,
    cpu7_ifu_fetch_ctl_if.master icu,
    output logic                 fq_dec_vld,
    output logic [31:0]          fq_dec_inst,
    output logic [31:0]          fq_dec_pc,
    input  logic                 dec_fq_rdy
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    ifq_state_e    r_state;
    ifq_state_e    w_state_nxt;
    logic [31:0]   r_fa;
    logic [31:0]   w_tgt;
    logic          w_redir;
    logic          w_req;
    logic          w_fill;
    logic          w_fq_vld;
    logic [CW-1:0] w_free;
    fq_entry_t     w_d0;
    fq_entry_t     w_d1;
    fq_entry_t     w_head;

    assign w_redir = exu_ifu_except | exu_ifu_ertn_e | br_taken;

    always_comb begin
        w_tgt = br_target;
        priority case (1'b1)
            exu_ifu_except: w_tgt = exu_ifu_eentry;
            exu_ifu_ertn_e: w_tgt = exu_ifu_era;
            default:        w_tgt = br_target;
        endcase
        w_tgt[1:0] = 2'b00;
    end

    // Two free slots are needed because an aligned block pushes two words.
    assign w_req  = (r_state == IFQ_S_REQ) && !w_redir && (w_free >= CW'(2));
    assign w_fill = (r_state == IFQ_S_WAIT) && icu.icu_ifu_data_valid_ic2 && !w_redir;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IFQ_S_REQ;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redir) begin
            w_state_nxt = IFQ_S_REQ;
        end else begin
            unique case (r_state)
                IFQ_S_REQ:  if (w_req && icu.icu_ifu_ack_ic1) w_state_nxt = IFQ_S_WAIT;
                IFQ_S_WAIT: if (icu.icu_ifu_data_valid_ic2) w_state_nxt = IFQ_S_REQ;
                default:    w_state_nxt = IFQ_S_REQ;
            endcase
        end
    end

    always_comb begin
        icu.ifu_icu_req_ic1  = 1'b0;
        icu.ifu_icu_addr_ic1 = '0;
        icu.ifu_icu_cancel   = 1'b0;
        if (!reset) begin
            icu.ifu_icu_req_ic1  = w_req;
            icu.ifu_icu_addr_ic1 = r_fa;
            // Only an accepted request with data still outstanding needs killing.
            icu.ifu_icu_cancel   = w_redir && (r_state == IFQ_S_WAIT) &&
                                   !icu.icu_ifu_data_valid_ic2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       r_fa <= pc_init;
        else if (w_redir) r_fa <= w_tgt;
        else if (w_fill)  r_fa <= next_block(r_fa);
    end

    // Odd-word start keeps only the high word; aligned start keeps both.
    always_comb begin
        w_d0.pc   = r_fa;
        w_d0.inst = r_fa[2] ? icu.icu_ifu_data_ic2[63:32] : icu.icu_ifu_data_ic2[31:0];
        w_d1.pc   = {r_fa[31:3], 3'b100};
        w_d1.inst = icu.icu_ifu_data_ic2[63:32];
    end

    cpu7_ifu_fq #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_redir),
        .i_push  (w_fill),
        .i_push2 (!r_fa[2]),
        .i_d0    (w_d0),
        .i_d1    (w_d1),
        .i_pop   (dec_fq_rdy && !w_redir),
        .o_vld   (w_fq_vld),
        .o_head  (w_head),
        .o_free  (w_free)
    );

    assign fq_dec_vld  = !reset && w_fq_vld;
    assign fq_dec_inst = reset ? '0 : w_head.inst;
    assign fq_dec_pc   = reset ? '0 : w_head.pc;

endmodule
